// File: rtl/mpu_pkg.sv
// Shared matrix-processing-unit definitions: opcodes, NOP class mask,
// BRAM select codes and the host issuer state type.
package mpu_pkg;

  localparam logic [3:0] OP_LOAD   = 4'b0100;
  localparam logic [3:0] OP_UNLOAD = 4'b0110;
  localparam logic [3:0] OP_COPY   = 4'b0101;
  localparam logic [3:0] OP_CLEAR  = 4'b0111;
  localparam logic [3:0] OP_ADD    = 4'b1100;
  localparam logic [3:0] OP_SHIFT  = 4'b1101;
  localparam logic [3:0] OP_SUB    = 4'b1110;
  localparam logic [3:0] OP_MULT   = 4'b1111;

  // Any opcode with both upper bits clear is a no-operation
  localparam logic [3:0] NOP_CLASS_MASK = 4'b1100;

  localparam logic [1:0] B0 = 2'b00;
  localparam logic [1:0] B1 = 2'b01;
  localparam logic [1:0] B2 = 2'b10;
  localparam logic [1:0] B3 = 2'b11;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    READY,
    ISSUE,
    ARM,
    RUN
  } issuer_state_t;

  function automatic logic is_nop_class(input logic [3:0] op);
    return (op & NOP_CLASS_MASK) == 4'b0000;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO holding host instructions; the head entry is
// visible on rdata whenever the FIFO is not empty.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/host_cmd_issuer.sv
// Buffers host instructions and issues them one at a time to the control FSM.
// Optional watchdog on ARM/RUN enabled by defining HOST_CMD_TIMEOUT_EN.
module host_cmd_issuer
  import mpu_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             cmd_in,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   fsm_busy,
  output logic [7:0]             host_instruction,
  output logic                   issued,
  output logic                   done,
  output logic                   dropped,
  output logic                   idle,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   timeout
);

  issuer_state_t state;
  issuer_state_t state_next;
  logic [7:0]    fifo_rdata;
  logic [7:0]    instr_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          issued_next;
  logic          done_next;
  logic          dropped_next;
  logic          tmo_hit;

  assign cmd_ready = !fifo_full;
  assign idle      = (state == READY) && fifo_empty;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .pop   (pop),
    .wdata (cmd_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_next   = state;
    instr_next   = host_instruction;
    pop          = 1'b0;
    issued_next  = 1'b0;
    done_next    = 1'b0;
    dropped_next = 1'b0;
    case (state)
      WAIT_IDLE: begin
        instr_next = {host_instruction[7:4], 4'h0};
        if (!fsm_busy) state_next = READY;
      end
      READY: begin
        if (!fifo_empty) begin
          if (is_nop_class(fifo_rdata[3:0])) begin
            pop          = 1'b1;
            dropped_next = 1'b1;
          end else if (!fsm_busy) begin
            pop         = 1'b1;
            instr_next  = fifo_rdata;
            issued_next = 1'b1;
            state_next  = ISSUE;
          end
        end
      end
      // Operands stay on the bus; the FSM keeps reading DD while it executes
      ISSUE: begin
        instr_next = {host_instruction[7:4], 4'h0};
        state_next = ARM;
      end
      // The FSM's one low cycle right after acceptance is not completion
      ARM: begin
        if (fsm_busy) state_next = RUN;
      end
      RUN: begin
        if (!fsm_busy) begin
          done_next  = 1'b1;
          state_next = READY;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase
    if (tmo_hit) begin
      state_next = WAIT_IDLE;
      done_next  = 1'b0;
      instr_next = {host_instruction[7:4], 4'h0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= WAIT_IDLE;
      host_instruction <= 8'h00;
      issued           <= 1'b0;
      done             <= 1'b0;
      dropped          <= 1'b0;
    end else begin
      state            <= state_next;
      host_instruction <= instr_next;
      issued           <= issued_next;
      done             <= done_next;
      dropped          <= dropped_next;
    end
  end

`ifdef HOST_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_count;

  assign tmo_hit = ((state == ARM) || (state == RUN)) &&
                   (tmo_count == TW'(TIMEOUT_CYCLES - 1));

  // FIFO contents survive a timeout; only the in-flight instruction is abandoned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_count <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= tmo_hit;
      if (issued_next)
        tmo_count <= '0;
      else if ((state == ARM) || (state == RUN))
        tmo_count <= tmo_count + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
  // Watchdog compiled out; the parameter stays referenced but the output is constant 0
  assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_host_cmd_issuer.sv
// Self-checking bench for host_cmd_issuer with a behavioural control-FSM model.
// Watchdog scenario is included when HOST_CMD_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_host_cmd_issuer;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    cmd_in = 8'h00;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          fsm_busy;
  logic [7:0]    host_instruction;
  logic          issued, done, dropped, idle, timeout;
  logic [CW-1:0] fifo_count;

  int total = 0;
  int bad   = 0;

  // 0: model reacts to instructions, 1: busy stuck high, 2: busy stuck low
  int         busy_mode = 1;
  int         pend_low = 0;
  int         busy_left = 0;
  logic [7:0] exec_q[$];
  logic [7:0] issued_q[$];
  int         done_cnt = 0;
  int         drop_cnt = 0;
  logic [7:0] last_issue = 8'h00;
  bit         chk_nop = 0;

  logic [3:0] fast_ops [6] = '{4'hC, 4'hD, 4'hE, 4'hF, 4'h5, 4'h7};

  always #5 clk = ~clk;

  host_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_in           (cmd_in),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .fsm_busy         (fsm_busy),
    .host_instruction (host_instruction),
    .issued           (issued),
    .done             (done),
    .dropped          (dropped),
    .idle             (idle),
    .fifo_count       (fifo_count),
    .timeout          (timeout)
  );

  // Control FSM model: accepts any non-NOP opcode it sees while idle, stays low
  // one cycle, then busy for 64 cycles (LOAD/UNLOAD) or 1 cycle (everything else)
  initial begin
    fsm_busy = 1'b1;
    forever begin
      @(negedge clk);
      if (busy_mode == 1) begin
        fsm_busy = 1'b1; pend_low = 0; busy_left = 0;
      end else if (busy_mode == 2) begin
        fsm_busy = 1'b0; pend_low = 0; busy_left = 0;
      end else if (pend_low > 0) begin
        fsm_busy = 1'b0; pend_low--;
      end else if (busy_left > 0) begin
        fsm_busy = 1'b1; busy_left--;
      end else begin
        fsm_busy = 1'b0;
        if (host_instruction[3:2] != 2'b00) begin
          exec_q.push_back(host_instruction);
          pend_low  = 1;
          busy_left = (host_instruction[3:2] == 2'b01 && !host_instruction[0]) ? 64 : 1;
        end
      end
    end
  end

  // Event log plus the rule that an issued instruction is followed by its NOP form
  always @(negedge clk) begin
    if (reset) begin
      chk_nop = 0;
    end else begin
      if (chk_nop) begin
        total++;
        if (host_instruction !== {last_issue[7:4], 4'h0}) begin
          bad++;
          $display("[TB] FAIL nop_after_issue: got %h expected %h", host_instruction, {last_issue[7:4], 4'h0});
        end
        chk_nop = 0;
      end
      if (issued) begin
        issued_q.push_back(host_instruction);
        last_issue = host_instruction;
        chk_nop = 1;
      end
      if (done)    done_cnt++;
      if (dropped) drop_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    exec_q.delete();
    issued_q.delete();
    done_cnt = 0;
    drop_cnt = 0;
  endtask

  task automatic push_cmd(input logic [7:0] c, output bit ok);
    int n = 0;
    cmd_in = c;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 2000) begin
      nstep();
      n++;
    end
    ok = cmd_ready;
    nstep();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_quiet(input int limit, output bit ok);
    int stable = 0;
    int n = 0;
    while (stable < 3 && n < limit) begin
      nstep();
      n++;
      if (idle && !fsm_busy && !cmd_valid) stable++;
      else stable = 0;
    end
    ok = (stable >= 3);
  endtask

  task automatic test_reset();
    int n = 0;
    busy_mode = 1;
    reset = 1'b1;
    repeat (2) nstep();
    total++;
    if (host_instruction !== 8'h00) begin bad++; $display("[TB] FAIL reset_instr: got %h expected 00", host_instruction); end
    total++;
    if (fifo_count !== '0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready); end
    total++;
    if ({issued, done, dropped, timeout, idle} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_flags: got %b expected 00000", {issued, done, dropped, timeout, idle});
    end
    reset = 1'b0;
    nstep();
    total++;
    if (idle !== 1'b0) begin bad++; $display("[TB] FAIL wait_idle_hold: got %b expected 0", idle); end
    busy_mode = 0;
    while (!idle && n < 10) begin nstep(); n++; end
    total++;
    if (idle !== 1'b1) begin bad++; $display("[TB] FAIL reach_ready: got %b expected 1", idle); end
  endtask

  task automatic test_add();
    bit ok;
    clear_log();
    push_cmd(8'h6C, ok);
    total++;
    if (fifo_count !== CW'(1) || host_instruction !== 8'h00 || issued !== 1'b0) begin
      bad++; $display("[TB] FAIL add_pre_issue: got cnt=%0d instr=%h issued=%b expected cnt=1 instr=00 issued=0", fifo_count, host_instruction, issued);
    end
    nstep();
    total++;
    if (issued !== 1'b1 || host_instruction !== 8'h6C) begin
      bad++; $display("[TB] FAIL add_issue: got issued=%b instr=%h expected issued=1 instr=6c", issued, host_instruction);
    end
    nstep();
    total++;
    if (issued !== 1'b0 || host_instruction !== 8'h60) begin
      bad++; $display("[TB] FAIL add_nop: got issued=%b instr=%h expected issued=0 instr=60", issued, host_instruction);
    end
    wait_quiet(30, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL add_quiet: got busy expected quiet"); end
    total++;
    if (done_cnt !== 1 || exec_q.size() !== 1) begin
      bad++; $display("[TB] FAIL add_done: got done=%0d exec=%0d expected 1 1", done_cnt, exec_q.size());
    end else begin
      total++;
      if (exec_q[0] !== 8'h6C) begin bad++; $display("[TB] FAIL add_exec: got %h expected 6c", exec_q[0]); end
    end
  endtask

  task automatic test_load();
    bit ok;
    int n = 0, hold_err = 0, busy_seen = 0, done_seen = 0;
    bit b1 = 0, b2 = 0, edge_ok = 0;
    clear_log();
    push_cmd(8'h84, ok);
    while (!issued && n < 10) begin nstep(); n++; end
    total++;
    if (issued !== 1'b1 || host_instruction !== 8'h84) begin
      bad++; $display("[TB] FAIL load_issue: got issued=%b instr=%h expected issued=1 instr=84", issued, host_instruction);
    end
    n = 0;
    while (!done_seen && n < 150) begin
      b2 = b1;
      b1 = fsm_busy;
      nstep();
      n++;
      if (host_instruction !== 8'h80) hold_err++;
      if (done) begin done_seen = 1; edge_ok = (b1 == 0) && (b2 == 1); end
      else if (fsm_busy) busy_seen++;
    end
    total++;
    if (!done_seen) begin bad++; $display("[TB] FAIL load_done: got none expected pulse"); end
    total++;
    if (hold_err != 0) begin bad++; $display("[TB] FAIL load_hold: got %0d bad cycles expected 0", hold_err); end
    total++;
    if (busy_seen != 64) begin bad++; $display("[TB] FAIL load_busy: got %0d expected 64", busy_seen); end
    total++;
    if (!edge_ok) begin bad++; $display("[TB] FAIL load_done_timing: got misaligned expected after busy fall"); end
    wait_quiet(40, ok);
    total++;
    if (!ok || issued_q.size() != 1 || exec_q.size() != 1) begin
      bad++; $display("[TB] FAIL load_reissue: got issued=%0d exec=%0d expected 1 1", issued_q.size(), exec_q.size());
    end
  endtask

  task automatic test_drop();
    bit ok;
    clear_log();
    push_cmd(8'h02, ok);
    push_cmd(8'h1F, ok);
    wait_quiet(40, ok);
    total++;
    if (drop_cnt != 1) begin bad++; $display("[TB] FAIL drop_count: got %0d expected 1", drop_cnt); end
    total++;
    if (!ok || issued_q.size() != 1 || exec_q.size() != 1) begin
      bad++; $display("[TB] FAIL drop_issue_count: got issued=%0d exec=%0d expected 1 1", issued_q.size(), exec_q.size());
    end else begin
      total++;
      if (issued_q[0] !== 8'h1F || exec_q[0] !== 8'h1F) begin
        bad++; $display("[TB] FAIL drop_issue_value: got %h/%h expected 1f", issued_q[0], exec_q[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int errs = 0;
    logic [7:0] sent[$];
    logic [7:0] c;
    clear_log();
    busy_mode = 1;
    repeat (2) nstep();
    for (int i = 0; i < DEPTH; i++) begin
      c = {4'($urandom_range(0, 15)), fast_ops[$urandom_range(0, 5)]};
      cmd_in = c;
      cmd_valid = 1'b1;
      nstep();
      sent.push_back(c);
      total++;
      if (fifo_count !== CW'(i + 1) || cmd_ready !== (i + 1 < DEPTH)) begin
        bad++; $display("[TB] FAIL fill_%0d: got cnt=%0d ready=%b expected cnt=%0d ready=%b", i, fifo_count, cmd_ready, i + 1, (i + 1 < DEPTH));
      end
    end
    cmd_in = 8'hFC;
    repeat (3) nstep();
    total++;
    if (fifo_count !== CW'(DEPTH) || cmd_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL full_reject: got cnt=%0d ready=%b expected cnt=%0d ready=0", fifo_count, cmd_ready, DEPTH);
    end
    cmd_valid = 1'b0;
    busy_mode = 0;
    wait_quiet(300, ok);
    total++;
    if (!ok || issued_q.size() != DEPTH || exec_q.size() != DEPTH || done_cnt != DEPTH) begin
      bad++; $display("[TB] FAIL drain_count: got issued=%0d exec=%0d done=%0d expected %0d", issued_q.size(), exec_q.size(), done_cnt, DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (issued_q[i] !== sent[i] || exec_q[i] !== sent[i]) errs++;
      total++;
      if (errs != 0) begin bad++; $display("[TB] FAIL drain_order: got %0d out of order expected 0", errs); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int push_fail = 0, errs = 0, exp_drop = 0;
    logic [7:0] exp_q[$];
    logic [7:0] c;
    clear_log();
    for (int i = 0; i < 24; i++) begin
      c = 8'($urandom);
      push_cmd(c, ok);
      if (!ok) push_fail++;
      if (c[3:2] == 2'b00) exp_drop++;
      else exp_q.push_back(c);
      repeat ($urandom_range(0, 3)) nstep();
    end
    wait_quiet(6000, ok);
    total++;
    if (push_fail != 0 || !ok) begin bad++; $display("[TB] FAIL rand_progress: got push_fail=%0d quiet=%b expected 0 1", push_fail, ok); end
    total++;
    if (drop_cnt != exp_drop) begin bad++; $display("[TB] FAIL rand_drops: got %0d expected %0d", drop_cnt, exp_drop); end
    total++;
    if (done_cnt != exp_q.size()) begin bad++; $display("[TB] FAIL rand_done: got %0d expected %0d", done_cnt, exp_q.size()); end
    total++;
    if (issued_q.size() != exp_q.size() || exec_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL rand_issue_count: got %0d/%0d expected %0d", issued_q.size(), exec_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i])
        if (issued_q[i] !== exp_q[i] || exec_q[i] !== exp_q[i]) errs++;
      total++;
      if (errs != 0) begin bad++; $display("[TB] FAIL rand_order: got %0d wrong expected 0", errs); end
    end
  endtask

  task automatic test_reset_run();
    bit ok;
    int n = 0;
    clear_log();
    push_cmd(8'h84, ok);
    push_cmd(8'h5C, ok);
    push_cmd(8'hAD, ok);
    push_cmd(8'h37, ok);
    while (!fsm_busy && n < 20) begin nstep(); n++; end
    repeat (3) nstep();
    total++;
    if (fifo_count !== CW'(3)) begin bad++; $display("[TB] FAIL run_queued: got %0d expected 3", fifo_count); end
    reset = 1'b1;
    #1;
    total++;
    if (host_instruction !== 8'h00 || fifo_count !== '0 || cmd_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL run_reset: got instr=%h cnt=%0d ready=%b expected 00 0 1", host_instruction, fifo_count, cmd_ready);
    end
    busy_mode = 1;
    repeat (3) nstep();
    reset = 1'b0;
    nstep();
    busy_mode = 0;
    wait_quiet(60, ok);
    total++;
    if (!ok || done_cnt != 0 || issued_q.size() != 1) begin
      bad++; $display("[TB] FAIL run_abort: got quiet=%b done=%0d issued=%0d expected 1 0 1", ok, done_cnt, issued_q.size());
    end
  endtask

`ifdef HOST_CMD_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int n = 0;
    clear_log();
    busy_mode = 2;
    nstep();
    push_cmd(8'h4C, ok);
    while (!issued && n < 10) begin nstep(); n++; end
    n = 0;
    while (!timeout && n < 40) begin nstep(); n++; end
    total++;
    if (n != 17) begin bad++; $display("[TB] FAIL timeout_delay: got %0d expected 17", n); end
    total++;
    if (idle !== 1'b0 || host_instruction[3:0] !== 4'h0) begin
      bad++; $display("[TB] FAIL timeout_nop: got idle=%b instr=%h expected idle=0 low nibble 0", idle, host_instruction);
    end
    nstep();
    total++;
    if (idle !== 1'b1 || timeout !== 1'b0) begin
      bad++; $display("[TB] FAIL timeout_recover: got idle=%b timeout=%b expected 1 0", idle, timeout);
    end
    busy_mode = 0;
    wait_quiet(20, ok);
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_load();
    test_drop();
    test_back_to_back();
    test_random();
    test_reset_run();
`ifdef HOST_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/host_cmd_issuer.md
# host_cmd_issuer

Instruction front end for the matrix processing unit. It buffers 8-bit host instructions in a small FIFO and issues them one at a time to the control FSM. Each instruction is presented for exactly one FSM sampling cycle. The block then holds the destination/source operand bits while the opcode is forced to NOP, and waits for the FSM's busy handshake to complete before issuing the next instruction. It sits directly upstream of the control FSM and drives that FSM's `host_instruction` input.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 128: watchdog limit in cycles; used only when `HOST_CMD_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `cmd_in` in 8: host instruction, `{DD[7:6], AA[5:4], opcode[3:0]}`.
- `cmd_valid` in 1: host offers `cmd_in`.
- `cmd_ready` out 1: FIFO not full; combinational from the occupancy count.
- `fsm_busy` in 1: busy output of the control FSM.
- `host_instruction` out 8: registered instruction to the FSM.
- `issued` out 1: one-cycle pulse when an instruction is placed on `host_instruction`.
- `done` out 1: one-cycle pulse when an issued instruction completes.
- `dropped` out 1: one-cycle pulse when a NOP command is discarded.
- `idle` out 1: high when the FIFO is empty and the issuer state is READY.
- `fifo_count` out $clog2(DEPTH)+1: FIFO occupancy.
- `timeout` out 1: watchdog pulse; tied to 0 when `HOST_CMD_TIMEOUT_EN` is not defined.

## Operation
Reset values:
- `host_instruction`=8'h00, `fifo_count`=0, `cmd_ready`=1.
- `issued`, `done`, `dropped`, `timeout`, `idle` = 0.
- State = WAIT_IDLE; FIFO is flushed.

Push and pop:
- A push occurs when `cmd_valid && cmd_ready`.
- A push and a pop in the same cycle leave `fifo_count` unchanged.
- A push while full is ignored; the host must hold `cmd_valid`.

State machine:
- WAIT_IDLE: drive NOP. When `fsm_busy`==0, go to READY.
- READY, FIFO empty: drive the NOP value currently on the output (low nibble 0).
- READY, head opcode[3:2]==2'b00 (NOP class): pop, pulse `dropped`, remain in READY. At most one drop per cycle.
- READY, valid head and `fsm_busy`==0: pop, load `host_instruction`=head, pulse `issued`, go to ISSUE.
- ISSUE (one cycle): set `host_instruction`={head[7:4], 4'h0}, go to ARM. The FSM has sampled the full opcode on this edge.
- ARM: hold the operand bits with NOP opcode. When `fsm_busy`==1, go to RUN.
- RUN: hold. When `fsm_busy`==0, pulse `done` and go to READY.

Why the extra states:
- The FSM reports busy=0 for one cycle after accepting an instruction. ARM exists so that cycle is not mistaken for completion.
- Operand bits [7:4] stay stable through ARM and RUN because the FSM reads DD during LOAD, ADD, etc.

Other behaviour:
- `idle` = READY && FIFO empty.
- Reset mid-operation aborts the in-flight instruction, flushes the FIFO, and returns to WAIT_IDLE. No `done` pulse is produced.

## Timing
- Issue latency: with the FIFO empty and READY, a push at edge N produces `host_instruction` = instruction after edge N+1. It is held exactly one cycle and replaced by NOP after edge N+2.
- Minimum gap between issues:
  - 1-cycle ops (ADD/SUB/SHIFT/MULT/COPY/CLEAR): ISSUE, ARM, RUN, READY, i.e. a new issue every 4 cycles.
  - LOAD/UNLOAD: 64 busy cycles plus overhead.
- `done` is asserted in the cycle after `fsm_busy` is sampled low in RUN.
- `cmd_ready` deasserts in the same cycle `fifo_count` reaches DEPTH.

## Configuration
- `HOST_CMD_TIMEOUT_EN` defined:
  - A cycle counter runs in ARM and RUN and clears on entering ISSUE.
  - When it reaches `TIMEOUT_CYCLES`, pulse `timeout`, drive NOP, and go to WAIT_IDLE.
  - The FIFO contents are kept.
- `HOST_CMD_TIMEOUT_EN` not defined: there is no counter, `timeout` is tied to 0, and ARM/RUN wait indefinitely.

## Structure
- Shared package `mpu_pkg` holds:
  - opcode constants (LOAD 4'b0100, UNLOAD 4'b0110, COPY 4'b0101, CLEAR 4'b0111, ADD 4'b1100, SHIFT 4'b1101, SUB 4'b1110, MULT 4'b1111);
  - the NOP class mask;
  - the BRAM select codes B0–B3;
  - the issuer state enum.
- One sub-module, `cmd_fifo`: synchronous FIFO with DEPTH/width parameters and push, pop, full, empty and count outputs.

## Test plan
- After reset, the FSM model raises busy for 1 cycle then drops it. Push 8'h6C (ADD, DD=01, AA=10) -> `host_instruction`=8'h6C for one cycle, then 8'h60; `issued` then `done`; the model executes one ADD.
- Push 8'h84 (LOAD to B2) with the model holding busy for 64 cycles -> 8'h80 is held throughout; `done` follows busy falling; no re-issue occurs.
- Push 8'h02 (NOP), then 8'h1F (MULT) -> `dropped` pulses once and only 8'h1F is issued.
- Push DEPTH+1 commands back-to-back while busy is stuck high -> `cmd_ready`=0 at `fifo_count`=8; the extra push is not accepted; commands drain in order once busy cycles.
- Assert reset while in RUN with 3 commands queued -> `host_instruction`=8'h00, `fifo_count`=0, no `done` pulse.
- With `HOST_CMD_TIMEOUT_EN` defined and TIMEOUT_CYCLES=16, hold busy low after issuing 8'h4C -> `timeout` pulses after 16 cycles and the state returns to WAIT_IDLE.
